// File: rtl/invaders_pkg.sv
// ============================================================================
// invaders_pkg : screen constants, shot-state encoding and colour type shared
//                by the invaders game blocks.            Rev 1.0
// ============================================================================
`default_nettype none

package invaders_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef logic [11:0] rgb444_t;

  typedef enum logic [3:0] {
    SHOT_IDLE = 4'b0001,
    SHOT_COOL = 4'b0010,
    SHOT_FLY  = 4'b0100,
    SHOT_HIT  = 4'b1000
  } shot_state_t;

  // Clamp an 11-bit intermediate to the 10-bit screen coordinate range.
  function automatic logic [9:0] sat10(input logic [10:0] v);
    return v[10] ? 10'h3FF : v[9:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter.sv
// ============================================================================
// counter : general counter with sync clear, load, wrapping up-count and
//           floor-at-zero down-count.                    Rev 1.0
// ============================================================================
`default_nettype none

module counter #(
  parameter int WIDTH_P = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [WIDTH_P-1:0] load_val_i,
  input  logic               up_i,
  input  logic               down_i,
  input  logic [WIDTH_P-1:0] wrap_i,
  output logic [WIDTH_P-1:0] count_o
);

  logic [WIDTH_P-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (up_i) begin
      count_d = (count_q == wrap_i) ? '0 : count_q + WIDTH_P'(1);
    end else if (down_i) begin
      count_d = (count_q == '0) ? '0 : count_q - WIDTH_P'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) count_q <= '0;
    else            count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/lfsr10.sv
// ============================================================================
// lfsr10 : 10-bit Fibonacci LFSR (taps 10,7) with advance enable; exposes
//          the low OUT_W_P bits.                         Rev 1.0
// ============================================================================
`default_nettype none

module lfsr10 #(
  parameter logic [9:0] SEED_P  = 10'h2A5,
  parameter int         OUT_W_P = 10
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  output logic [OUT_W_P-1:0] value_o
);

  logic [9:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) lfsr_q <= SEED_P;
    else            lfsr_q <= lfsr_d;
  end

  assign value_o = lfsr_q[OUT_W_P-1:0];

endmodule

`default_nettype wire

// File: rtl/enemy_shot.sv
// ============================================================================
// enemy_shot : owns the single enemy bullet - cooldown, random launch under
//              the fleet, descent and player hit detection.   Rev 1.0
// ============================================================================
`default_nettype none

module enemy_shot
  import invaders_pkg::*;
#(
  parameter rgb444_t     color_p    = 12'b1111_1111_0000,
  parameter int unsigned tick_div_p = 250000,
  parameter int unsigned step_p     = 4,
  parameter int unsigned gap_p      = 30,
  parameter int unsigned player_y_p = 440,
  parameter int unsigned screen_h_p = SCREEN_H,
  parameter int unsigned bullet_w_p = 2,
  parameter int unsigned bullet_h_p = 8,
  parameter logic [9:0]  seed_p     = 10'h2A5
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  input  logic        freeze_i,
  input  logic [9:0]  fleet_left_i,
  input  logic [9:0]  fleet_right_i,
  input  logic [9:0]  fleet_bottom_i,
  input  logic [9:0]  player_left_i,
  input  logic [9:0]  player_right_i,
  output logic        hit_o,
  output logic        active_o,
  output logic [9:0]  bullet_x_o,
  output logic [9:0]  bullet_y_o,
  output logic [11:0] color_o,
  output logic [3:0]  state_o
);

  localparam int TICK_W = (tick_div_p > 1) ? $clog2(tick_div_p) : 1;
  localparam int GAP_W  = (gap_p > 0) ? $clog2(gap_p + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_WRAP = TICK_W'(tick_div_p - 1);

  shot_state_t state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [TICK_W-1:0] tick_cnt;
  logic [GAP_W-1:0]  cool_cnt;
  logic [7:0]  rnd;
  logic        tick, cool_load, cool_done, hit_cond, miss_cond;
  logic [10:0] x_sum;
  logic [9:0]  launch_x, launch_y, y_step;

  // The divider only runs once the game is live so launch latency is
  // measured from COOL entry.
  assign tick = enable_i && !freeze_i && (state_q != SHOT_IDLE) && (tick_cnt == TICK_WRAP);

  counter #(.WIDTH_P(TICK_W)) u_tick_cnt (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .clr_i      (!enable_i || (state_q == SHOT_IDLE)),
    .load_i     (1'b0),
    .load_val_i ('0),
    .up_i       (!freeze_i),
    .down_i     (1'b0),
    .wrap_i     (TICK_WRAP),
    .count_o    (tick_cnt)
  );

  counter #(.WIDTH_P(GAP_W)) u_cool_cnt (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .clr_i      (!enable_i),
    .load_i     (cool_load),
    .load_val_i (GAP_W'(gap_p)),
    .up_i       (1'b0),
    .down_i     (tick && (state_q == SHOT_COOL)),
    .wrap_i     ('0),
    .count_o    (cool_cnt)
  );

  lfsr10 #(.SEED_P(seed_p), .OUT_W_P(8)) u_lfsr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (!freeze_i),
    .value_o   (rnd)
  );

  // Launch happens on the tick that takes the cooldown to zero.
  assign cool_done = (cool_cnt == GAP_W'(0)) || (cool_cnt == GAP_W'(1));

  assign x_sum    = {1'b0, fleet_left_i} + {3'b000, rnd};
  assign launch_x = (x_sum > {1'b0, fleet_right_i}) ? fleet_right_i : x_sum[9:0];
  assign launch_y = sat10({1'b0, fleet_bottom_i} + 11'd1);
  assign y_step   = sat10({1'b0, y_q} + 11'(step_p));

  assign hit_cond  = (({1'b0, y_q} + 11'(bullet_h_p)) > 11'(player_y_p))
                  && (x_q <= player_right_i)
                  && (({1'b0, x_q} + 11'(bullet_w_p) - 11'd1) >= {1'b0, player_left_i});
  assign miss_cond = ({1'b0, y_q} >= 11'(screen_h_p));

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cool_load = 1'b0;
    if (!enable_i) begin
      state_d = SHOT_IDLE;
      x_d     = '0;
      y_d     = '0;
    end else begin
      case (state_q)
        SHOT_IDLE: begin
          state_d   = SHOT_COOL;
          cool_load = 1'b1;
        end
        SHOT_COOL: begin
          if (tick && cool_done) begin
            state_d = SHOT_FLY;
            x_d     = launch_x;
            y_d     = launch_y;
          end
        end
        SHOT_FLY: begin
          if (!freeze_i) begin
            if (hit_cond) begin
              state_d = SHOT_HIT;
            end else if (miss_cond) begin
              state_d   = SHOT_COOL;
              cool_load = 1'b1;
            end else if (tick) begin
              y_d = y_step;
            end
          end
        end
        SHOT_HIT: begin
          state_d   = SHOT_COOL;
          cool_load = 1'b1;
        end
        default: state_d = SHOT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= SHOT_IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign hit_o      = (state_q == SHOT_HIT);
  assign active_o   = (state_q == SHOT_FLY) || (state_q == SHOT_HIT);
  assign bullet_x_o = x_q;
  assign bullet_y_o = y_q;
  assign color_o    = color_p;
  assign state_o    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_enemy_shot.sv
// ============================================================================
// tb_enemy_shot : directed table-driven bench for enemy_shot.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_enemy_shot;

  logic        clk_i = 1'b0;
  logic        reset_n_i, enable_i, freeze_i;
  logic [9:0]  fleet_left_i, fleet_right_i, fleet_bottom_i;
  logic [9:0]  player_left_i, player_right_i;
  logic        hit_o, active_o;
  logic [9:0]  bullet_x_o, bullet_y_o;
  logic [11:0] color_o;
  logic [3:0]  state_o;

  localparam logic [3:0] S_IDLE = 4'b0001, S_COOL = 4'b0010, S_FLY = 4'b0100, S_HIT = 4'b1000;

  always #5 clk_i = ~clk_i;

  enemy_shot #(.tick_div_p(4), .gap_p(2)) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .enable_i       (enable_i),
    .freeze_i       (freeze_i),
    .fleet_left_i   (fleet_left_i),
    .fleet_right_i  (fleet_right_i),
    .fleet_bottom_i (fleet_bottom_i),
    .player_left_i  (player_left_i),
    .player_right_i (player_right_i),
    .hit_o          (hit_o),
    .active_o       (active_o),
    .bullet_x_o     (bullet_x_o),
    .bullet_y_o     (bullet_y_o),
    .color_o        (color_o),
    .state_o        (state_o)
  );

  typedef struct {
    int fl, fr, fb, pl, pr;
    int exp_x;      // -1: derive from the LFSR reference
    int exp_hit;
    int exp_end_y;
  } vec_t;

  vec_t vecs[7];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference LFSR: advances on every unfrozen clock
  logic [9:0] m_lfsr;
  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)     m_lfsr <= 10'h2A5;
    else if (!freeze_i) m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_inputs(input vec_t v);
    fleet_left_i   = v.fl[9:0];
    fleet_right_i  = v.fr[9:0];
    fleet_bottom_i = v.fb[9:0];
    player_left_i  = v.pl[9:0];
    player_right_i = v.pr[9:0];
  endtask

  function automatic int model_x(input int fl, input int fr, input logic [9:0] l);
    int s;
    s = fl + int'(l[7:0]);
    return (s > fr) ? fr : s;
  endfunction

  task automatic wait_launch(output bit ok, output logic [9:0] snap);
    ok   = 1'b0;
    snap = m_lfsr;
    for (int i = 0; i < 300; i++) begin
      snap = m_lfsr;
      @(negedge clk_i);
      if (active_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("launch_seen", int'(ok), 1);
  endtask

  task automatic follow(input vec_t v, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_i);
      if (hit_o) begin
        done = 1'b1;
        check({tag, "_hit"}, 1, v.exp_hit);
        check({tag, "_hit_state"}, int'(state_o), int'(S_HIT));
        check({tag, "_hit_y"}, int'(bullet_y_o), v.exp_end_y);
        @(negedge clk_i);
        check({tag, "_hit_len"}, int'(hit_o), 0);
        check({tag, "_after_hit"}, int'(state_o), int'(S_COOL));
        break;
      end else if (state_o == S_COOL) begin
        done = 1'b1;
        check({tag, "_hit"}, 0, v.exp_hit);
        check({tag, "_miss_y"}, int'(bullet_y_o), v.exp_end_y);
        check({tag, "_miss_active"}, int'(active_o), 0);
        break;
      end
    end
    check({tag, "_end_seen"}, int'(done), 1);
  endtask

  task automatic wait_y_change(output bit ok);
    logic [9:0] y0;
    y0 = bullet_y_o;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (bullet_y_o != y0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit         ok;
    logic [9:0] snap, fx, fy;
    logic [3:0] fs;
    int         c, cool_at, ex;
    vec_t       fv;

    //          fl   fr    fb   pl    pr    x   hit  end_y
    vecs[0] = '{100, 600,  399, 1000, 1010, -1,  0,  480};
    vecs[1] = '{310, 310,  399, 300,  330,  310, 1,  436};
    vecs[2] = '{400, 400,  399, 0,    20,   400, 0,  480};
    vecs[3] = '{299, 299,  427, 300,  330,  299, 1,  436};
    vecs[4] = '{298, 298,  427, 300,  330,  298, 0,  480};
    vecs[5] = '{500, 520,  399, 1000, 1010, -1,  0,  480};
    vecs[6] = '{0,   1023, 99,  1000, 1010, -1,  0,  480};

    reset_n_i = 1'b0;
    enable_i  = 1'b0;
    freeze_i  = 1'b0;
    set_inputs(vecs[0]);
    repeat (3) @(negedge clk_i);
    check("rst_state",  int'(state_o),    int'(S_IDLE));
    check("rst_hit",    int'(hit_o),      0);
    check("rst_active", int'(active_o),   0);
    check("rst_x",      int'(bullet_x_o), 0);
    check("rst_y",      int'(bullet_y_o), 0);
    check("color",      int'(color_o),    12'hFF0);
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("idle_hold", int'(state_o), int'(S_IDLE));

    for (int i = 0; i < 7; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      if (i == 0) begin
        enable_i = 1'b1;
        c = 0;
        cool_at = -1;
        snap = m_lfsr;
        for (int k = 0; k < 40; k++) begin
          snap = m_lfsr;
          @(negedge clk_i);
          c++;
          if (state_o == S_COOL && cool_at < 0) cool_at = c;
          if (state_o == S_FLY) break;
        end
        check("cool_entry", cool_at, 1);
        check("launch_latency", c - cool_at, 8);
      end else begin
        set_inputs(vecs[i]);
        wait_launch(ok, snap);
      end
      ex = (vecs[i].exp_x < 0) ? model_x(vecs[i].fl, vecs[i].fr, snap) : vecs[i].exp_x;
      check({tag, "_state"}, int'(state_o),    int'(S_FLY));
      check({tag, "_x"},     int'(bullet_x_o), ex);
      check({tag, "_y"},     int'(bullet_y_o), vecs[i].fb + 1);
      follow(vecs[i], tag);
    end

    // Freeze mid-flight for 20 ticks
    fv = '{0, 1023, 299, 1000, 1010, -1, 0, 480};
    set_inputs(fv);
    wait_launch(ok, snap);
    check("frz_launch_x", int'(bullet_x_o), model_x(0, 1023, snap));
    wait_y_change(ok);
    wait_y_change(ok);
    check("frz_moving", int'(ok), 1);
    freeze_i = 1'b1;
    fx = bullet_x_o;
    fy = bullet_y_o;
    fs = state_o;
    repeat (80) @(negedge clk_i);
    check("frz_x",     int'(bullet_x_o), int'(fx));
    check("frz_y",     int'(bullet_y_o), int'(fy));
    check("frz_state", int'(state_o),    int'(fs));
    freeze_i = 1'b0;
    wait_y_change(ok);
    check("frz_resume", int'(ok), 1);
    check("frz_step",   int'(bullet_y_o), int'(fy) + 4);
    follow(fv, "frz");
    // Next launch exposes whether the DUT LFSR paused along with the reference
    wait_launch(ok, snap);
    check("post_frz_x", int'(bullet_x_o), model_x(0, 1023, snap));

    // Enable dropped mid-flight
    repeat (2) @(negedge clk_i);
    check("en_pre_fly", int'(state_o), int'(S_FLY));
    enable_i = 1'b0;
    @(negedge clk_i);
    check("en_state",  int'(state_o),    int'(S_IDLE));
    check("en_active", int'(active_o),   0);
    check("en_hit",    int'(hit_o),      0);
    check("en_x",      int'(bullet_x_o), 0);
    check("en_y",      int'(bullet_y_o), 0);
    enable_i = 1'b1;

    // Asynchronous reset mid-flight, observed between clock edges
    wait_launch(ok, snap);
    check("rst_pre_fly", int'(state_o), int'(S_FLY));
    #1 reset_n_i = 1'b0;
    #1;
    check("arst_state",  int'(state_o),  int'(S_IDLE));
    check("arst_active", int'(active_o), 0);
    check("arst_hit",    int'(hit_o),    0);
    check("arst_y",      int'(bullet_y_o), 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/enemy_shot.md
# enemy_shot

Enemy-side counterpart of the player ship: owns the single enemy bullet, fires it from a pseudo-random column under the fleet, and steps it down the screen. It tests each bullet position against the player's reported span and generates the one-cycle `hit` pulse that the player FSM consumes. The block sits between the fleet controller (which supplies the fleet extent), the player (which supplies its position and consumes the hit), and the renderer (which draws the bullet).

## Interface
- `color_p`, 12'b1111_1111_0000: RGB444 bullet colour, passed to `color_o`.
- `tick_div_p`, 250000: clock cycles per movement tick.
- `step_p`, 4: pixels the bullet descends per tick.
- `gap_p`, 30: ticks of cooldown between the end of one shot and the launch of the next.
- `player_y_p`, 440: top row of the player ship.
- `screen_h_p`, 480: row at which a missed bullet retires.
- `bullet_w_p`, 2: bullet width in pixels.
- `bullet_h_p`, 8: bullet height in pixels.
- `seed_p`, 10'h2A5: LFSR reset value, which must be nonzero.
- `clk_i` in 1: clock.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `enable_i` in 1: game running. When low, the block is held in IDLE.
- `freeze_i` in 1: pause, driven from the player "shot but alive" state. Freezes all state.
- `fleet_left_i` in 10: leftmost x of the live fleet.
- `fleet_right_i` in 10: rightmost x of the live fleet.
- `fleet_bottom_i` in 10: lowest y of the live fleet.
- `player_left_i` in 10: leftmost x of the player.
- `player_right_i` in 10: rightmost x of the player.
- `hit_o` out 1: one-cycle pulse when the bullet strikes the player.
- `active_o` out 1: bullet is on screen.
- `bullet_x_o` out 10: left x of the bullet.
- `bullet_y_o` out 10: top y of the bullet.
- `color_o` out 12: equals `color_p`.
- `state_o` out 4: one-hot present state, for debug.

## Operation
States are one-hot:
- IDLE = 4'b0001
- COOL = 4'b0010
- FLY = 4'b0100
- HIT = 4'b1000

Tick generator:
- The tick counter counts 0 to `tick_div_p-1` and wraps.
- `tick` is high for one cycle at the wrap.
- The counter holds while `freeze_i` is high or `enable_i` is low.

LFSR:
- 10-bit Fibonacci LFSR, taps 10 and 7.
- Advances every cycle while the block is not frozen.

Transitions:
- IDLE to COOL when `enable_i` is high. The cooldown counter loads `gap_p`.
- COOL: the counter decrements on each `tick`. When it reaches 0 on a `tick`, the block launches and moves to FLY.
- Launch position: x = `fleet_left_i` + {2'b0, lfsr[7:0]}, saturated to `fleet_right_i` if the sum exceeds it. y = `fleet_bottom_i` + 1.
- FLY: on each `tick`, y advances by `step_p`.
- Hit condition (combinational, on the registered x/y): y + `bullet_h_p` > `player_y_p`, AND x ≤ `player_right_i`, AND x + `bullet_w_p` - 1 ≥ `player_left_i`. When true, the next state is HIT.
- Miss: if the hit condition is false and y ≥ `screen_h_p`, the bullet retires. The next state is COOL with `gap_p` reloaded.
- HIT always lasts exactly one cycle, then moves to COOL with `gap_p` reloaded. Freeze does not hold HIT.

Global rules:
- `enable_i` low, in any state: synchronous return to IDLE. The bullet clears and the counters reset.
- `freeze_i` high, in COOL or FLY: no state, position, or counter changes.
- A hit and a miss on the same cycle: hit wins.
- Arithmetic is 11-bit internally so that y + `step_p` cannot wrap. y saturates at 1023.

## Timing
Reset values:
- state = IDLE
- `hit_o` = 0, `active_o` = 0, `bullet_x_o` = 0, `bullet_y_o` = 0
- LFSR = `seed_p`
- tick counter = 0, cooldown counter = 0

Output timing:
- `hit_o` = (state == HIT) and is registered. It asserts exactly one cycle, starting the cycle after the hit condition is first true in FLY.
- `active_o` = (state == FLY) | (state == HIT).
- Launch latency: `gap_p` ticks after entry to COOL. Position and state update on the same clock edge.
- Position outputs are registered and change only on a `tick` or at launch.
- Asserting reset during FLY forces IDLE asynchronously. `hit_o` drops immediately.

## Structure
- Shared package `invaders_pkg`: screen constants (640, 480), the `shot_state_t` enum, and the RGB444 colour typedef.
- Reuse the existing `counter` module for the tick divider and the cooldown counter.
- One new sub-module: `lfsr10` (parameterised seed, enable input).

## Test plan
- Reset and enable with `gap_p`=2, `tick_div_p`=4 → FLY entered 8 cycles after COOL; launch x = `fleet_left_i` + lfsr[7:0] (first value from seed 10'h2A5), y = `fleet_bottom_i`+1.
- Player span [300,330]; bullet at x=310 descending → exactly one `hit_o` cycle when y first exceeds 432, then COOL.
- Player span [0,20]; bullet at x=400 → no `hit_o`; retires once y ≥ 480, then re-launches after `gap_p` ticks.
- Edge overlap: x=299, `bullet_w_p`=2, player_left=300 → hit. x=298 → miss.
- Raise `freeze_i` for 20 ticks mid-flight → x/y, state and LFSR all unchanged; motion resumes the tick after release.
- `enable_i` low mid-flight, and separately `reset_n_i` low mid-flight → IDLE, `active_o`=0, `hit_o`=0; the reset case takes effect without a clock edge.
